// File: rtl/prefix8_block_accumulator.sv
// Block accumulator wrapped around an external 8-bit prefix adder: sums BLOCK_LEN samples per result.
// Build option PREFIX8_ACC_SATURATE_EN clamps the accumulator at 8'hFF instead of wrapping.
module prefix8_block_accumulator #(
  parameter int BLOCK_LEN = 8,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic             flush,
  output logic [7:0]       add_a,
  output logic [7:0]       add_b,
  input  logic [7:0]       add_sum,
  input  logic             add_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_sum,
  output logic             out_ovf,
  output logic [CNT_W-1:0] out_count
);

  localparam logic [0:0]       ST_ACC   = 1'b0;
  localparam logic [0:0]       ST_STALL = 1'b1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLOCK_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  logic [0:0]       state_q, state_d;
  logic [7:0]       acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [7:0]       out_sum_q, out_sum_d;
  logic             out_ovf_q, out_ovf_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;

  logic             slot_free_s;
  logic             in_ready_s;
  logic             accept_s;
  logic             close_s;
  logic             write_s;
  logic [7:0]       acc_nx_s;
  logic             ovf_nx_s;
  logic [CNT_W-1:0] cnt_nx_s;

  // Handshake decode: only the block-closing sample is held back while the slot is busy.
  always_comb begin
    slot_free_s = !out_valid_q || out_ready;
    case (state_q)
      ST_ACC:   in_ready_s = slot_free_s || (cnt_q != CNT_LAST);
      ST_STALL: in_ready_s = 1'b0;
      default:  in_ready_s = 1'b0;
    endcase
    accept_s = in_valid && in_ready_s;
    if (state_q == ST_ACC) begin
      close_s = (accept_s && (cnt_q == CNT_LAST)) || (flush && ((cnt_q != CNT_ZERO) || accept_s));
    end else begin
      close_s = 1'b0;
    end
    write_s = (close_s && slot_free_s) || ((state_q == ST_STALL) && out_ready);
  end

  // Running block state including the current sample, if one is accepted this cycle.
  always_comb begin
    acc_nx_s = acc_q;
    ovf_nx_s = ovf_q;
    cnt_nx_s = cnt_q;
    if (accept_s) begin
`ifdef PREFIX8_ACC_SATURATE_EN
      if (add_cout || ((acc_q == 8'hFF) && (in_data != 8'h00))) begin
        acc_nx_s = 8'hFF;
      end else begin
        acc_nx_s = add_sum;
      end
`else
      acc_nx_s = add_sum;
`endif
      ovf_nx_s = ovf_q | add_cout;
      cnt_nx_s = cnt_q + CNT_W'(1);
    end else begin
      acc_nx_s = acc_q;
      ovf_nx_s = ovf_q;
      cnt_nx_s = cnt_q;
    end
  end

  // Next state: a write publishes the block and restarts from zero; a blocked close parks in STALL.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_nx_s;
    ovf_d       = ovf_nx_s;
    cnt_d       = cnt_nx_s;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_ovf_d   = out_ovf_q;
    out_count_d = out_count_q;
    if (write_s) begin
      out_valid_d = 1'b1;
      out_sum_d   = acc_nx_s;
      out_ovf_d   = ovf_nx_s;
      out_count_d = cnt_nx_s;
      acc_d       = 8'h00;
      ovf_d       = 1'b0;
      cnt_d       = CNT_ZERO;
      state_d     = ST_ACC;
    end else begin
      if (out_ready) begin
        out_valid_d = 1'b0;
      end else begin
        out_valid_d = out_valid_q;
      end
      if (close_s) begin
        state_d = ST_STALL;
      end else begin
        state_d = state_q;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_ACC;
      acc_q       <= 8'h00;
      ovf_q       <= 1'b0;
      cnt_q       <= CNT_ZERO;
      out_valid_q <= 1'b0;
      out_sum_q   <= 8'h00;
      out_ovf_q   <= 1'b0;
      out_count_q <= CNT_ZERO;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_ovf_q   <= out_ovf_d;
      out_count_q <= out_count_d;
    end
  end

  assign in_ready  = in_ready_s;
  assign add_a     = acc_q;
  assign add_b     = in_data;
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_ovf   = out_ovf_q;
  assign out_count = out_count_q;

endmodule

// File: tb/tb_prefix8_block_accumulator.sv
// Randomised and directed bench for prefix8_block_accumulator (BLOCK_LEN=4) with a queue-based block model.
module tb_prefix8_block_accumulator;

  localparam int L = 4;
  localparam int CW = 8;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    in_data;
  logic          flush;
  logic [7:0]    add_a;
  logic [7:0]    add_b;
  logic [7:0]    add_sum;
  logic          add_cout;
  logic          out_valid;
  logic          out_ready;
  logic [7:0]    out_sum;
  logic          out_ovf;
  logic [CW-1:0] out_count;

  int checks;
  int failures;

  typedef struct {
    int sum;
    int ovf;
    int count;
  } blk_t;

  int   cur[$];
  blk_t q[$];

  prefix8_block_accumulator #(.BLOCK_LEN(L), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .flush(flush),
    .add_a(add_a), .add_b(add_b), .add_sum(add_sum), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_ovf(out_ovf), .out_count(out_count)
  );

  // Behavioural 8-bit adder sitting between add_a/add_b and add_sum/add_cout.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic blk_t close_block();
    blk_t b;
    int total;
    total = 0;
    foreach (cur[i]) total += cur[i];
`ifdef PREFIX8_ACC_SATURATE_EN
    b.sum = (total > 255) ? 255 : total;
`else
    b.sum = total % 256;
`endif
    b.ovf   = (total > 255) ? 1 : 0;
    b.count = cur.size();
    return b;
  endfunction

  // One clock: drive at posedge+1, compare and update the model at the falling edge.
  task automatic cycle(input logic v, input logic [7:0] d, input logic fl, input logic ordy);
    logic exp_ready;
    logic acc;
    logic cons;
    in_valid  = v;
    in_data   = d;
    flush     = fl;
    out_ready = ordy;
    @(negedge clk);
    exp_ready = !(q.size() == 2) && !((cur.size() == L - 1) && (q.size() >= 1) && !ordy);
    check_eq("out_valid", out_valid, (q.size() >= 1) ? 32'd1 : 32'd0);
    check_eq("in_ready", in_ready, exp_ready);
    check_eq("add_b", add_b, d);
    acc  = v && in_ready;
    cons = out_valid && ordy;
    if (cons) begin
      if (q.size() > 0) begin
        check_eq("out_sum", out_sum, q[0].sum);
        check_eq("out_ovf", out_ovf, q[0].ovf);
        check_eq("out_count", out_count, q[0].count);
        void'(q.pop_front());
      end else begin
        check_eq("unexpected_result", 32'd1, 32'd0);
      end
    end
    if (acc) cur.push_back(int'(d));
    if ((cur.size() == L) || (fl && (cur.size() > 0))) begin
      q.push_back(close_block());
      cur.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic samples4(input int a, input int b, input int c, input int d);
    cycle(1'b1, 8'(a), 1'b0, 1'b1);
    cycle(1'b1, 8'(b), 1'b0, 1'b1);
    cycle(1'b1, 8'(c), 1'b0, 1'b1);
    cycle(1'b1, 8'(d), 1'b0, 1'b1);
  endtask

  initial begin
    int guard;
    checks   = 0;
    failures = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    flush     = 1'b0;
    out_ready = 1'b0;
    #12;
    check_eq("rst_out_valid", out_valid, 32'd0);
    check_eq("rst_out_sum", out_sum, 32'd0);
    check_eq("rst_out_ovf", out_ovf, 32'd0);
    check_eq("rst_out_count", out_count, 32'd0);
    check_eq("rst_in_ready", in_ready, 32'd1);
    check_eq("rst_add_a", add_a, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    samples4(10, 20, 30, 40);
    check_eq("blk1_valid", out_valid, 32'd1);
    check_eq("blk1_sum", out_sum, 32'd100);
    check_eq("blk1_ovf", out_ovf, 32'd0);
    check_eq("blk1_count", out_count, 32'd4);

    samples4(200, 100, 1, 1);
`ifdef PREFIX8_ACC_SATURATE_EN
    check_eq("ovf_sum", out_sum, 32'd255);
`else
    check_eq("ovf_sum", out_sum, 32'd46);
`endif
    check_eq("ovf_flag", out_ovf, 32'd1);

    // Slot held full: three samples go in, the closing one waits for out_ready.
    cycle(1'b1, 8'd3, 1'b0, 1'b0);
    cycle(1'b1, 8'd4, 1'b0, 1'b0);
    cycle(1'b1, 8'd5, 1'b0, 1'b0);
    in_valid = 1'b1; in_data = 8'd6; out_ready = 1'b0;
    #2;
    check_eq("blocked_ready", in_ready, 32'd0);
    cycle(1'b1, 8'd6, 1'b0, 1'b0);
    cycle(1'b1, 8'd6, 1'b0, 1'b1);
    check_eq("unblock_sum", out_sum, 32'd18);
    check_eq("unblock_count", out_count, 32'd4);

    cycle(1'b1, 8'd5, 1'b0, 1'b1);
    cycle(1'b1, 8'd6, 1'b0, 1'b1);
    cycle(1'b0, 8'd0, 1'b1, 1'b1);
    check_eq("flush_sum", out_sum, 32'd11);
    check_eq("flush_count", out_count, 32'd2);
    cycle(1'b0, 8'd0, 1'b1, 1'b1);

    samples4(1, 1, 1, 1);
    check_eq("restart_sum", out_sum, 32'd4);

    cycle(1'b1, 8'd9, 1'b0, 1'b1);
    cycle(1'b1, 8'd9, 1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_valid", out_valid, 32'd0);
    check_eq("midrst_ready", in_ready, 32'd1);
    check_eq("midrst_sum", out_sum, 32'd0);
    cur.delete();
    q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    samples4(7, 7, 7, 7);
    check_eq("post_rst_sum", out_sum, 32'd28);
    check_eq("post_rst_count", out_count, 32'd4);

    // Flush against an occupied slot parks the block until out_ready.
    cycle(1'b1, 8'd2, 1'b0, 1'b0);
    cycle(1'b1, 8'd3, 1'b1, 1'b0);
    cycle(1'b1, 8'd4, 1'b1, 1'b0);
    cycle(1'b1, 8'd4, 1'b0, 1'b0);
    cycle(1'b1, 8'd4, 1'b0, 1'b1);
    cycle(1'b0, 8'd0, 1'b0, 1'b1);

    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0, 8'($urandom_range(0, 255)),
            ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0,
            ($urandom_range(0, 4) < 3) ? 1'b1 : 1'b0);
    end

    guard = 0;
    while (((q.size() > 0) || (cur.size() > 0)) && (guard < 50)) begin
      cycle(1'b0, 8'd0, 1'b1, 1'b1);
      guard++;
    end
    check_eq("drain_empty", q.size() + cur.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prefix8_block_accumulator.md
Name: prefix8_block_accumulator

Overview:
- Sequential stage directly upstream and downstream of the 8-bit prefix adder.
- Drives the adder's `a`/`b` operands and registers the adder's `sum`/`cout` back into an accumulator.
- Sums a stream of 8-bit samples into blocks of BLOCK_LEN samples, with a sticky carry-out (overflow) flag.
- Emits one result per block (or per flush) through a valid/ready output slot.

Parameters:
- BLOCK_LEN, 8, samples per block; legal range 1..255.
- CNT_W, 8, width of the sample counter and of `out_count`; must hold BLOCK_LEN.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  sample present.
- in_ready  output  1  sample accepted when in_valid && in_ready.
- in_data  input  8  sample value.
- flush  input  1  level request to close a partial block.
- add_a  output  8  adder operand a; equals acc register.
- add_b  output  8  adder operand b; equals in_data.
- add_sum  input  8  adder sum (combinational return).
- add_cout  input  1  adder carry-out.
- out_valid  output  1  result slot full.
- out_ready  input  1  consumer takes the result when out_valid && out_ready.
- out_sum  output  8  block sum.
- out_ovf  output  1  at least one carry-out occurred in the block.
- out_count  output  CNT_W  samples in the block, 1..BLOCK_LEN.

Behaviour:
- Interface: clock is `clk`; reset is `rst_n`, asynchronous, active-low.
- Reset values: acc=0, ovf=0, cnt=0, out_valid=0, out_sum=0, out_ovf=0, out_count=0, state=ACC.
- The adder path is purely combinational (acc, in_data -> add_sum); acc is the only register on the loop.
- States:
  - ACC: in_ready=1, except when an accept would close the block while the slot is blocked.
  - STALL: in_ready=0.
- Slot free: `slot_free = !out_valid || out_ready`.
- close condition: `close = (accept && cnt==BLOCK_LEN-1) || (flush && (cnt>0 || accept))`.
- In ACC, in_ready = slot_free || (cnt != BLOCK_LEN-1).
  - in_ready depends combinationally on out_ready; this path is allowed.
  - Mid-block samples are therefore accepted while the slot is occupied.
- Accept without close: acc<=add_sum, ovf<=ovf|add_cout, cnt<=cnt+1.
- Close with slot_free:
  - out_sum<=next acc value, out_ovf<=next ovf, out_count<=cnt+accept, out_valid<=1.
  - acc<=0, ovf<=0, cnt<=0.
- Close requested but slot not free: enter STALL; acc, ovf and cnt hold.
  - STALL -> ACC on the first cycle out_ready=1; the pending block is written that cycle.
  - The next block starts from acc=0.
- Flush:
  - flush with cnt==0 and no accept: ignored.
  - flush together with an accept: the sample is included, then the block closes.
  - flush held in STALL: no extra effect.
- Output drain: out_valid && out_ready with no new close -> out_valid<=0, out_sum/out_ovf/out_count hold their last value.
- Back-to-back: drain and close in the same cycle -> out_valid stays 1 with new contents.
- Full throughput: one sample per cycle while the consumer keeps out_ready=1.
- Latency: result visible on out_* one cycle after the closing accept.
- Reset mid-block or in STALL: all partial state discarded, outputs to reset values.
- in_data is ignored when in_valid=0.
- add_b follows in_data unconditionally.

Optional Feature:
- Macro: PREFIX8_ACC_SATURATE_EN.
- Defined: on any accept where add_cout=1, or acc already 8'hFF with in_data!=0, acc<=8'hFF. ovf is still set.
- Undefined: acc<=add_sum (modulo-256 wrap); ovf records the carry.

Test Plan:
- BLOCK_LEN=4, out_ready=1, samples 10,20,30,40 -> one cycle after the 4th accept: out_valid=1, out_sum=100, out_ovf=0, out_count=4.
- BLOCK_LEN=4, samples 200,100,1,1 -> no macro: out_sum=46, out_ovf=1; with PREFIX8_ACC_SATURATE_EN: out_sum=255, out_ovf=1.
- BLOCK_LEN=4, out_ready=0 after the first block:
  - next 3 samples accepted; 4th sample (in_valid=1) sees in_ready=0.
  - Raising out_ready -> the 4th sample is accepted that cycle and the block is written; first result consumed; no sample lost.
- Samples 5,6 then flush=1 one cycle -> out_sum=11, out_count=2.
- Next block 1,1,1,1 -> out_sum=4, confirming acc restarted at 0.
- Reset pulse (rst_n=0, asynchronous, mid-cycle) after 2 of 4 samples -> out_valid=0, in_ready=1 immediately.
- Then samples 7,7,7,7 -> out_sum=28, out_count=4.
